// File: rtl/plot_sequencer.sv
// Plot-enable sequencer: debounced Next/Previous/Auto buttons select one of N_PLOTS
// generators through a one-hot enable, deferring every switch while the plot is busy.
module plot_sequencer #(
    parameter int N_PLOTS      = 4,
    parameter int DEB_CYCLES   = 16,
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int IDX_W        = $clog2(N_PLOTS)
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               bt_next,
    input  logic               bt_pre,
    input  logic               bt_auto,
    input  logic               plot_busy,
    output logic [N_PLOTS-1:0] enable_sw,
    output logic [IDX_W-1:0]   plot_idx,
    output logic               auto_on,
    output logic               switch_pulse
);

    localparam int NBTN     = 3;
    localparam int BTN_NEXT = 0;
    localparam int BTN_PRE  = 1;
    localparam int BTN_AUTO = 2;
    localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int DWELL_W  = $clog2(DWELL_CYCLES);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(N_PLOTS - 1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return i + IDX_W'(1);
        end
    endfunction

    function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] i);
        if (i == {IDX_W{1'b0}}) begin
            return IDX_W'(N_PLOTS - 1);
        end else begin
            return i - IDX_W'(1);
        end
    endfunction

    function automatic logic [N_PLOTS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_PLOTS-1:0] v;
        for (int k = 0; k < N_PLOTS; k++) begin
            v[k] = (i == IDX_W'(k));
        end
        return v;
    endfunction

    logic [NBTN-1:0]    raw_s;
    logic [NBTN-1:0]    sync1_q;
    logic [NBTN-1:0]    sync2_q;
    logic [NBTN-1:0]    stable_q;
    logic [NBTN-1:0]    stable_d;
    logic [NBTN-1:0]    press_q;
    logic [NBTN-1:0]    press_d;
    logic [DEB_W-1:0]   deb_cnt_q [NBTN];
    logic [DEB_W-1:0]   deb_cnt_d [NBTN];

    logic               next_ev_s;
    logic               pre_ev_s;
    logic               auto_ev_s;
    logic               manual_s;
    logic               tick_s;
    logic               step_up_s;
    logic               step_dn_s;

    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic               auto_on_q;
    logic               auto_on_d;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   target_q;
    logic [IDX_W-1:0]   target_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [IDX_W-1:0]   base_s;
    logic [N_PLOTS-1:0] en_q;
    logic [N_PLOTS-1:0] en_d;
    logic               pulse_q;
    logic               pulse_d;

    assign raw_s = {bt_auto, bt_pre, bt_next};

    // Debouncer: level flips after DEB_CYCLES consecutive differing samples; rising flip is a press
    always_comb begin
        for (int b = 0; b < NBTN; b++) begin
            stable_d[b]  = stable_q[b];
            press_d[b]   = 1'b0;
            deb_cnt_d[b] = {DEB_W{1'b0}};
            if (sync2_q[b] == stable_q[b]) begin
                deb_cnt_d[b] = {DEB_W{1'b0}};
            end else if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
                stable_d[b] = ~stable_q[b];
                press_d[b]  = ~stable_q[b];
            end else begin
                deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
            end
        end
    end

    // Synchronizers, debounce counters, stable levels and registered press events
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1_q  <= {NBTN{1'b0}};
            sync2_q  <= {NBTN{1'b0}};
            stable_q <= {NBTN{1'b0}};
            press_q  <= {NBTN{1'b0}};
            for (int b = 0; b < NBTN; b++) begin
                deb_cnt_q[b] <= {DEB_W{1'b0}};
            end
        end else begin
            sync1_q  <= raw_s;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            for (int b = 0; b < NBTN; b++) begin
                deb_cnt_q[b] <= deb_cnt_d[b];
            end
        end
    end

    assign next_ev_s = press_q[BTN_NEXT];
    assign pre_ev_s  = press_q[BTN_PRE];
    assign auto_ev_s = press_q[BTN_AUTO];
    assign manual_s  = next_ev_s | pre_ev_s;
    assign tick_s    = auto_on_q & (state_q == ST_IDLE) & (dwell_q == DWELL_W'(DWELL_CYCLES - 1));
    // Next+Pre cancel each other; any manual press suppresses a coincident auto-tick.
    assign step_up_s = (next_ev_s & ~pre_ev_s) | (tick_s & ~manual_s);
    assign step_dn_s = pre_ev_s & ~next_ev_s;

    // Auto toggle and dwell timer; the timer only runs in auto mode while nothing is pending
    always_comb begin
        auto_on_d = auto_on_q ^ auto_ev_s;
        if (!auto_on_q) begin
            dwell_d = {DWELL_W{1'b0}};
        end else if (manual_s || tick_s || (state_q != ST_IDLE)) begin
            dwell_d = {DWELL_W{1'b0}};
        end else begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
    end

    // Dwell timer and auto-mode flag
    always_ff @(posedge sysclk) begin
        if (rst) begin
            dwell_q   <= {DWELL_W{1'b0}};
            auto_on_q <= 1'b0;
        end else begin
            dwell_q   <= dwell_d;
            auto_on_q <= auto_on_d;
        end
    end

    // Request/commit sequencing; a new step is applied on top of whatever target commits this cycle
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        idx_d    = idx_q;
        en_d     = en_q;
        pulse_d  = 1'b0;
        base_s   = idx_q;
        case (state_q)
            ST_IDLE: begin
                base_s = idx_q;
            end
            ST_PENDING: begin
                base_s = target_q;
                if (!plot_busy) begin
                    state_d = ST_IDLE;
                    if (target_q != idx_q) begin
                        idx_d   = target_q;
                        en_d    = onehot(target_q);
                        pulse_d = 1'b1;
                    end else begin
                        pulse_d = 1'b0;
                    end
                end else begin
                    state_d = ST_PENDING;
                end
            end
            default: begin
                state_d = ST_IDLE;
                base_s  = idx_q;
            end
        endcase
        if (step_up_s) begin
            target_d = idx_inc(base_s);
            state_d  = ST_PENDING;
        end else if (step_dn_s) begin
            target_d = idx_dec(base_s);
            state_d  = ST_PENDING;
        end else begin
            target_d = target_q;
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= {IDX_W{1'b0}};
            idx_q    <= {IDX_W{1'b0}};
            en_q     <= onehot({IDX_W{1'b0}});
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            pulse_q  <= pulse_d;
        end
    end

    assign enable_sw    = en_q;
    assign plot_idx     = idx_q;
    assign auto_on      = auto_on_q;
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_plot_sequencer.sv
// Directed bench for plot_sequencer: cycle-by-cycle comparison against a net-offset
// reference model plus hand-computed latency and position expectations.
module tb_plot_sequencer;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int W  = 50;
    localparam int IW = 2;
    localparam int P  = W + 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          bt_next   = 1'b0;
    logic          bt_pre    = 1'b0;
    logic          bt_auto   = 1'b0;
    logic          plot_busy = 1'b0;
    logic [N-1:0]  enable_sw;
    logic [IW-1:0] plot_idx;
    logic          auto_on;
    logic          switch_pulse;

    always #5 clk = ~clk;

    plot_sequencer #(
        .N_PLOTS(N), .DEB_CYCLES(D), .DWELL_CYCLES(W), .IDX_W(IW)
    ) dut (
        .sysclk(clk), .rst(rst), .bt_next(bt_next), .bt_pre(bt_pre), .bt_auto(bt_auto),
        .plot_busy(plot_busy), .enable_sw(enable_sw), .plot_idx(plot_idx),
        .auto_on(auto_on), .switch_pulse(switch_pulse)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int chk_en   = 0;
    int commits [$];
    int auto_rise = -1;
    int auto_fall = -1;
    int prev_auto = 0;

    // Reference model: button history per input, a pending flag and a signed net step count.
    int m_s1 [3];
    int m_s2 [3];
    int m_stable [3];
    int m_run [3];
    int m_press [3];
    int m_auto = 0, m_dwell = 0, m_pending = 0, m_offset = 0, m_idx = 0, m_pulse = 0;

    function automatic int wrap(input int v);
        return ((v % N) + N) % N;
    endfunction

    task automatic model_step();
        int raw [3];
        int ev_n, ev_p, ev_a, manual, tick, step;
        raw[0] = int'(bt_next);
        raw[1] = int'(bt_pre);
        raw[2] = int'(bt_auto);
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; m_run[b] = 0; m_press[b] = 0;
            end
            m_auto = 0; m_dwell = 0; m_pending = 0; m_offset = 0; m_idx = 0; m_pulse = 0;
        end else begin
            ev_n = m_press[0];
            ev_p = m_press[1];
            ev_a = m_press[2];
            for (int b = 0; b < 3; b++) begin
                m_press[b] = 0;
                if (m_s2[b] != m_stable[b]) begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] == D) begin
                        m_stable[b] = 1 - m_stable[b];
                        m_run[b] = 0;
                        m_press[b] = m_stable[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
            manual = (ev_n != 0 || ev_p != 0) ? 1 : 0;
            tick   = (m_auto != 0 && m_pending == 0 && m_dwell == W - 1) ? 1 : 0;
            if (ev_n != 0 && ev_p == 0) step = 1;
            else if (ev_p != 0 && ev_n == 0) step = -1;
            else if (manual == 0 && tick != 0) step = 1;
            else step = 0;
            if (m_auto == 0 || manual != 0 || m_pending != 0 || tick != 0) m_dwell = 0;
            else m_dwell = m_dwell + 1;
            if (ev_a != 0) m_auto = 1 - m_auto;
            m_pulse = 0;
            if (m_pending != 0 && plot_busy == 1'b0) begin
                if (wrap(m_offset) != 0) begin
                    m_idx = wrap(m_idx + m_offset);
                    m_pulse = 1;
                end
                m_pending = 0;
                m_offset = 0;
            end
            if (step != 0) begin
                m_pending = 1;
                m_offset = m_offset + step;
            end
        end
    endtask

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        check("schedule", (cyc <= t) ? 1 : 0, 1);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: bt_next = v;
            1: bt_pre  = v;
            2: bt_auto = v;
            default: bt_next = v;
        endcase
    endtask

    task automatic press(input int b, input int hold);
        set_btn(b, 1'b1);
        wait_cyc(hold);
        set_btn(b, 1'b0);
    endtask

    function automatic int commit_at(input int i);
        if (i < commits.size()) return commits[i];
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_enable"}, enable_sw, 4'b0001);
        check({tag, "_idx"}, plot_idx, 0);
        check({tag, "_auto"}, auto_on, 0);
        check({tag, "_pulse"}, switch_pulse, 0);
    endtask

    initial begin
        int t0, tb, a, c4, tm, ca, tq, n0, r;
        logic [N-1:0] exp_en;
        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(posedge clk);
                #1;
                if (switch_pulse === 1'b1) commits.push_back(cyc);
                if (auto_on === 1'b1 && prev_auto == 0) auto_rise = cyc;
                if (auto_on === 1'b0 && prev_auto == 1) auto_fall = cyc;
                prev_auto = (auto_on === 1'b1) ? 1 : 0;
            end
            forever begin
                @(negedge clk);
                if (chk_en != 0) begin
                    exp_en = N'(1) << m_idx;
                    check("cyc_enable_sw", enable_sw, exp_en);
                    check("cyc_plot_idx", plot_idx, m_idx);
                    check("cyc_auto_on", auto_on, m_auto);
                    check("cyc_switch_pulse", switch_pulse, m_pulse);
                end
            end
        join_none

        rst = 1'b1;
        @(negedge clk);
        chk_en = 1;
        wait_cyc(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cyc(3);

        // Single Next press: switch lands D+4 edges after the raw edge.
        commits.delete();
        t0 = cyc;
        press(0, D + 10);
        wait_cyc(D + 8);
        check("next_count", commits.size(), 1);
        check("next_latency", commit_at(0) - t0, D + 4);
        check("next_idx", plot_idx, 1);
        check("next_enable", enable_sw, 4'b0010);

        // Glitches shorter than the debounce window.
        commits.delete();
        repeat (4) begin
            press(0, D - 2);
            wait_cyc(3);
        end
        press(1, D - 2);
        wait_cyc(D + 8);
        check("glitch_count", commits.size(), 0);
        check("glitch_idx", plot_idx, 1);

        // Previous twice: 1 -> 0 -> wrap to 3.
        press(1, D + 6);
        wait_cyc(D + 6);
        check("pre_idx0", plot_idx, 0);
        press(1, D + 6);
        wait_cyc(D + 6);
        check("pre_wrap_idx", plot_idx, 3);
        check("pre_wrap_enable", enable_sw, 4'b1000);

        // Busy: next, next, pre accumulate to +1 and commit only after busy falls.
        plot_busy = 1'b1;
        commits.delete();
        press(0, D + 4);
        wait_cyc(D + 6);
        press(0, D + 4);
        wait_cyc(D + 6);
        press(1, D + 4);
        wait_cyc(D + 6);
        check("busy_hold_count", commits.size(), 0);
        check("busy_hold_idx", plot_idx, 3);
        tb = cyc;
        plot_busy = 1'b0;
        wait_cyc(4);
        check("busy_commit_count", commits.size(), 1);
        check("busy_commit_time", commit_at(0), tb + 1);
        check("busy_commit_idx", plot_idx, 0);
        check("busy_commit_enable", enable_sw, 4'b0001);

        // Next then Previous while busy: no switch and no pulse.
        plot_busy = 1'b1;
        commits.delete();
        press(0, D + 4);
        wait_cyc(D + 6);
        press(1, D + 4);
        wait_cyc(D + 6);
        plot_busy = 1'b0;
        wait_cyc(4);
        check("cancel_count", commits.size(), 0);
        check("cancel_idx", plot_idx, 0);

        // Auto mode: commits every DWELL+1 cycles from the auto_on rise, wrapping 3 -> 0.
        commits.delete();
        t0 = cyc;
        press(2, D + 6);
        check("auto_rise_latency", auto_rise - t0, D + 3);
        a = auto_rise;
        wait_until(a + 4 * P + 2);
        check("auto_count", commits.size(), 4);
        for (int i = 0; i < 4; i++) check("auto_period", commit_at(i), a + (i + 1) * P);
        check("auto_wrap_idx", plot_idx, 0);

        // Manual Next at dwell count 40 restarts the timer.
        c4 = a + 4 * P;
        wait_until(c4 + 22);
        tm = cyc;
        press(0, D + 6);
        wait_until(c4 + 42 + P + 2);
        check("manual_commit", commit_at(4), tm + D + 4);
        check("manual_then_auto", commit_at(5) - commit_at(4), P);
        check("manual_auto_idx", plot_idx, 2);

        // Previous landing on the same edge as an auto-tick: Previous wins.
        ca = commit_at(5);
        wait_until(ca + W - D - 3);
        press(1, D + 6);
        wait_until(ca + W + 4);
        check("tick_pre_time", commit_at(6), ca + W + 1);
        check("tick_pre_idx", plot_idx, 1);

        // Second auto press stops advancing.
        tq = cyc;
        press(2, D + 6);
        check("auto_fall_latency", auto_fall - tq, D + 3);
        wait_cyc(2);
        n0 = commits.size();
        wait_cyc(3 * P);
        check("auto_off_count", commits.size(), n0);
        check("auto_off_flag", auto_on, 0);
        check("auto_off_idx", plot_idx, 1);

        // Reset while a request is pending and Next is held through reset.
        plot_busy = 1'b1;
        bt_next = 1'b1;
        wait_cyc(D + 5);
        rst = 1'b1;
        wait_cyc(3);
        check_reset_outputs("midrst");
        plot_busy = 1'b0;
        r = cyc;
        rst = 1'b0;
        commits.delete();
        wait_cyc(D + 8);
        check("rst_press_count", commits.size(), 1);
        check("rst_press_time", commit_at(0), r + D + 4);
        check("rst_press_idx", plot_idx, 1);
        bt_next = 1'b0;
        wait_cyc(D + 6);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
